// File: rtl/sa_job_sequencer.sv
// Job sequencer for the TicSAT systolic array: weight load, activation stream, pipeline flush.
// Optional performance counters are built when SA_SEQ_PERF_CNT_EN is defined.

package TicSAT_pkg;

    typedef enum logic [1:0] {
        CMD_NONE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_QUEUE         = 2'd2,
        CMD_STREAM        = 2'd3
    } command_t;

    // Per-byte int8 two's complement to sign-magnitude; -128 maps to 0x80.
    function automatic logic [31:0] twos_complement_to_sign_mag(input logic [31:0] v);
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = v[8*i +: 8];
            n = 8'd0 - b;
            r[8*i +: 8] = b[7] ? {1'b1, n[6:0]} : b;
        end
        return r;
    endfunction

endpackage

module sa_job_sequencer
    import TicSAT_pkg::*;
#(
    parameter int unsigned SA_SIZE      = 4,
    parameter int unsigned FILL_WORDS   = 2 * SA_SIZE,
    parameter int unsigned WEIGHT_WORDS = SA_SIZE * SA_SIZE / 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [15:0]                rows_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic                       w_valid_i,
    output logic                       w_ready_o,
    input  logic [31:0]                w_data_i,
    input  logic                       a_valid_i,
    output logic                       a_ready_o,
    input  logic [31:0]                a_data_i,
    output logic                       o_valid_o,
    input  logic                       o_ready_i,
    output logic [31:0]                o_data_o,
    output TicSAT_pkg::command_t       sa_cmd_o,
    output logic [31:0]                sa_in_val_o,
    output logic [$clog2(SA_SIZE)-1:0] sa_in_idx_o,
    input  logic [31:0]                sa_out_i
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles_o,
    output logic [31:0]                job_cycles_o
`endif
);

    localparam int unsigned IDX_W = $clog2(SA_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_rows;
    logic [31:0] r_widx;
    logic [31:0] w_widx_d;
    logic        r_o_valid;
    logic [31:0] r_o_data;

    logic [31:0]      w_n_words;
    logic [31:0]      w_total;
    logic [IDX_W-1:0] w_idx;
    logic             w_kept;
    logic             w_out_free;
    logic             w_can_issue;
    logic             w_issue_qs;
    logic             w_start_acc;
    command_t         w_qs_cmd;

    // r_widx counts weight words in LOAD_W, then QUEUE/STREAM commands k through STREAM and DRAIN.
    assign w_n_words   = 32'(r_rows) << IDX_W;
    assign w_total     = w_n_words + 32'(FILL_WORDS);
    assign w_idx       = r_widx[IDX_W-1:0];
    assign w_kept      = r_widx >= 32'(FILL_WORDS);
    assign w_out_free  = !r_o_valid || o_ready_i;
    assign w_can_issue = !w_kept || w_out_free;
    assign w_qs_cmd    = (w_idx == IDX_W'(SA_SIZE - 1)) ? CMD_STREAM : CMD_QUEUE;
    assign w_start_acc = (r_state == StIdle) && start_i && !abort_i;

    always_comb begin
        w_state_d   = r_state;
        w_widx_d    = r_widx;
        w_issue_qs  = 1'b0;
        sa_cmd_o    = CMD_NONE;
        sa_in_val_o = '0;
        sa_in_idx_o = '0;
        w_ready_o   = 1'b0;
        a_ready_o   = 1'b0;
        done_o      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_d = StLoadW;
                    w_widx_d  = '0;
                end
            end
            StLoadW: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    sa_cmd_o    = CMD_WRITE_WEIGHTS;
                    sa_in_val_o = twos_complement_to_sign_mag(w_data_i);
                    sa_in_idx_o = w_idx;
                    if (r_widx == 32'(WEIGHT_WORDS - 1)) begin
                        w_widx_d  = '0;
                        w_state_d = (r_rows != '0) ? StStream : StDone;
                    end else begin
                        w_widx_d = r_widx + 32'd1;
                    end
                end
            end
            StStream: begin
                a_ready_o = w_can_issue;
                if (a_valid_i && w_can_issue) begin
                    sa_cmd_o    = w_qs_cmd;
                    sa_in_val_o = a_data_i;
                    sa_in_idx_o = w_idx;
                    w_issue_qs  = 1'b1;
                    w_widx_d    = r_widx + 32'd1;
                    if (r_widx == w_n_words - 32'd1) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (r_widx != w_total) begin
                    if (w_can_issue) begin
                        sa_cmd_o    = w_qs_cmd;
                        sa_in_idx_o = w_idx;
                        w_issue_qs  = 1'b1;
                        w_widx_d    = r_widx + 32'd1;
                    end
                end else if (w_out_free) begin
                    // Last kept word leaves the output register this cycle.
                    w_state_d = StDone;
                end
            end
            StDone: begin
                done_o    = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (abort_i) begin
            w_state_d   = StIdle;
            w_widx_d    = r_widx;
            w_issue_qs  = 1'b0;
            sa_cmd_o    = CMD_NONE;
            sa_in_val_o = '0;
            sa_in_idx_o = '0;
            w_ready_o   = 1'b0;
            a_ready_o   = 1'b0;
            done_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_rows    <= '0;
            r_widx    <= '0;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_widx  <= w_widx_d;
            if (w_start_acc) begin
                r_rows <= rows_i;
            end
            if (abort_i) begin
                r_o_valid <= 1'b0;
            end else if (w_issue_qs && w_kept) begin
                r_o_valid <= 1'b1;
                r_o_data  <= sa_out_i;
            end else if (o_ready_i) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign busy_o    = (r_state != StIdle);
    assign o_valid_o = r_o_valid;
    assign o_data_o  = r_o_data;

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_job_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cycles <= '0;
            r_job_cycles   <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
            r_job_cycles   <= '0;
        end else if (busy_o) begin
            r_job_cycles <= r_job_cycles + 32'd1;
            if (sa_cmd_o == CMD_NONE) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign job_cycles_o   = r_job_cycles;
`endif

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Scoreboard bench for sa_job_sequencer; the array is modelled as a FILL-deep delay line.
module tb_sa_job_sequencer;
    import TicSAT_pkg::*;

    localparam int SA   = 4;
    localparam int FILL = 8;
    localparam int WW   = 4;
    localparam logic [31:0] MASK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst, start, abort, w_valid, a_valid, o_ready;
    logic [15:0] rows;
    logic [31:0] w_data, a_data, sa_out;
    logic        busy, done, w_ready, a_ready, o_valid;
    logic [31:0] o_data, sa_in_val;
    logic [1:0]  sa_in_idx;
    command_t    sa_cmd;
`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles, job_cycles;
`endif

    always #5 clk = ~clk;

    sa_job_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .rows_i      (rows),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_data_i    (w_data),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_data_i    (a_data),
        .o_valid_o   (o_valid),
        .o_ready_i   (o_ready),
        .o_data_o    (o_data),
        .sa_cmd_o    (sa_cmd),
        .sa_in_val_o (sa_in_val),
        .sa_in_idx_o (sa_in_idx),
        .sa_out_i    (sa_out)
`ifdef SA_SEQ_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .job_cycles_o   (job_cycles)
`endif
    );

    // Array model: output of command k is the input of command k-FILL, xored with MASK.
    logic [31:0] hist [64];
    int          hcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= 0;
        end else if (start && !busy) begin
            hcnt <= 0;
        end else if (sa_cmd == CMD_QUEUE || sa_cmd == CMD_STREAM) begin
            if (hcnt < 64) hist[hcnt] <= sa_in_val;
            hcnt <= hcnt + 1;
        end
    end
    assign sa_out = (hcnt >= FILL && hcnt < 64 + FILL) ? (hist[hcnt - FILL] ^ MASK) : 32'hDEAD_BEEF;

    typedef struct {
        command_t    cmd;
        logic [1:0]  idx;
        logic [31:0] val;
    } cmd_rec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] out_q[$];
    cmd_rec_t    cmd_log[$];
    logic [31:0] wwords [WW];
    logic [31:0] avals [16];
    int done_cnt, done_cyc, done_outs, first_wr_cyc;
    int stall_bad, stab_bad, gap_bad, abort_cmd_bad, timeout, aborted;

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b1;
        rows = '0; w_data = '0; a_data = '0;
    endtask

    // Drives one job cycle by cycle and records commands, accepted inputs and outputs.
    task automatic run_job(input int m, input bit gappy, input int hold, input int abort_at,
                           input int restart_cyc, input bit stop_drain);
        int wsent, asent, hold_left;
        bit hold_started, prev_stall;
        logic [31:0] prev_data;
        cmd_rec_t rec;
        exp_q.delete(); out_q.delete(); cmd_log.delete();
        done_cnt = 0; done_cyc = -1; done_outs = -1; first_wr_cyc = -1;
        stall_bad = 0; stab_bad = 0; gap_bad = 0; abort_cmd_bad = 0; timeout = 0; aborted = 0;
        wsent = 0; asent = 0; hold_left = 0; hold_started = 0; prev_stall = 0; prev_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (stop_drain && m > 0 && asent == m * SA) return;
            if (hold > 0 && !hold_started && o_valid) begin
                hold_started = 1;
                hold_left = hold;
            end
            o_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            start   = (cyc == 0) || (cyc == restart_cyc);
            rows    = 16'(m);
            w_valid = (wsent < WW);
            w_data  = wwords[wsent % WW];
            a_valid = (asent < m * SA) && (!gappy || (cyc % 2 == 0));
            a_data  = avals[asent % 16];
            abort   = (abort_at >= 0) && (asent == abort_at) && o_valid;
            #1;
            if (prev_stall && (!o_valid || o_data !== prev_data)) stab_bad++;
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            if (w_ready && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (!o_ready && o_valid && (sa_cmd == CMD_QUEUE || sa_cmd == CMD_STREAM)) stall_bad++;
            if (gappy && asent > 0 && asent < m * SA && !a_valid && sa_cmd != CMD_NONE) gap_bad++;
            if (abort && sa_cmd != CMD_NONE) abort_cmd_bad++;
            if (sa_cmd != CMD_NONE) begin
                rec.cmd = sa_cmd; rec.idx = sa_in_idx; rec.val = sa_in_val;
                cmd_log.push_back(rec);
            end
            if (w_valid && w_ready) wsent++;
            if (a_valid && a_ready) begin
                exp_q.push_back(a_data ^ MASK);
                asent++;
            end
            if (o_valid && o_ready) out_q.push_back(o_data);
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_outs = out_q.size();
            end
            if (abort) aborted = 1;
            if (abort || done) return;
        end
        timeout = 1;
    endtask

    function automatic int qs_bad(input int m);
        int k;
        int bad;
        k = 0; bad = 0;
        foreach (cmd_log[i]) begin
            if (cmd_log[i].cmd == CMD_WRITE_WEIGHTS) continue;
            if (cmd_log[i].idx != 2'(k % SA)) bad++;
            if (cmd_log[i].cmd != ((k % SA == SA - 1) ? CMD_STREAM : CMD_QUEUE)) bad++;
            if (cmd_log[i].val != ((k < m * SA) ? avals[k % 16] : 32'h0)) bad++;
            k++;
        end
        return bad;
    endfunction

    function automatic int count_cmd(input command_t c);
        int n;
        n = 0;
        foreach (cmd_log[i]) if (cmd_log[i].cmd == c) n++;
        return n;
    endfunction

    function automatic int qs_count();
        return count_cmd(CMD_QUEUE) + count_cmd(CMD_STREAM);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready: got %b, expected 0", w_ready); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b, expected 0", a_ready); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b, expected 0", o_valid); end
        n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_o_data: got %h, expected 0", o_data); end
        n_checks++; if (sa_cmd !== CMD_NONE) begin n_fail++; $display("FAIL reset_cmd: got %0d, expected 0", sa_cmd); end
        n_checks++; if (sa_in_val !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %h, expected 0", sa_in_val); end
        n_checks++; if (sa_in_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d, expected 0", sa_in_idx); end
        rst = 1'b0;
    endtask

    task automatic test_weights_only();
        foreach (wwords[i]) wwords[i] = 32'hFF01_807F;
        run_job(0, 0, 0, -1, -1, 0);
        idle_inputs();
        n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL w_timeout: got %0d, expected 0", timeout); end
        n_checks++; if (cmd_log.size() != 4) begin n_fail++; $display("FAIL w_cmd_count: got %0d, expected 4", cmd_log.size()); end
        for (int i = 0; i < cmd_log.size() && i < 4; i++) begin
            n_checks++;
            if (cmd_log[i].cmd !== CMD_WRITE_WEIGHTS || cmd_log[i].idx !== 2'(i) || cmd_log[i].val !== 32'h8101_807F) begin
                n_fail++;
                $display("FAIL w_cmd%0d: got cmd=%0d idx=%0d val=%h, expected cmd=1 idx=%0d val=8101807f",
                         i, cmd_log[i].cmd, cmd_log[i].idx, cmd_log[i].val, i);
            end
        end
        n_checks++; if (first_wr_cyc != 1) begin n_fail++; $display("FAIL w_first_ready: got %0d, expected 1", first_wr_cyc); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL w_done_count: got %0d, expected 1", done_cnt); end
        n_checks++; if (done_cyc != 5) begin n_fail++; $display("FAIL w_done_cycle: got %0d, expected 5", done_cyc); end
        n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL w_outputs: got %0d, expected 0", out_q.size()); end
    endtask

    task automatic test_stream_m2();
        logic [31:0] got, exp;
        wwords[0] = 32'h0102_0304; wwords[1] = 32'hFFFE_FDFC; wwords[2] = 32'h7F80_0001; wwords[3] = 32'h1122_3344;
        run_job(2, 0, 0, -1, -1, 0);
        idle_inputs();
        n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL s_timeout: got %0d, expected 0", timeout); end
        n_checks++; if (count_cmd(CMD_WRITE_WEIGHTS) != 4) begin n_fail++; $display("FAIL s_wcmds: got %0d, expected 4", count_cmd(CMD_WRITE_WEIGHTS)); end
        n_checks++; if (qs_count() != 16) begin n_fail++; $display("FAIL s_qs_count: got %0d, expected 16", qs_count()); end
        n_checks++; if (qs_bad(2) != 0) begin n_fail++; $display("FAIL s_qs_pattern: got %0d bad, expected 0", qs_bad(2)); end
        n_checks++; if (out_q.size() != 8) begin n_fail++; $display("FAIL s_out_count: got %0d, expected 8", out_q.size()); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL s_result: got %h, expected %h", got, exp); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL s_done_count: got %0d, expected 1", done_cnt); end
        n_checks++; if (done_cyc != 22) begin n_fail++; $display("FAIL s_done_cycle: got %0d, expected 22", done_cyc); end
        n_checks++; if (done_outs != 8) begin n_fail++; $display("FAIL s_done_after_last: got %0d, expected 8", done_outs); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, exp;
        run_job(1, 0, 10, -1, -1, 0);
        idle_inputs();
        n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d, expected 0", timeout); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_issue_in_stall: got %0d, expected 0", stall_bad); end
        n_checks++; if (stab_bad != 0) begin n_fail++; $display("FAIL bp_data_stable: got %0d, expected 0", stab_bad); end
        n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL bp_out_count: got %0d, expected 4", out_q.size()); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bp_result: got %h, expected %h", got, exp); end
        end
        n_checks++; if (done_cyc != 28) begin n_fail++; $display("FAIL bp_done_cycle: got %0d, expected 28", done_cyc); end
    endtask

    task automatic test_gappy();
        logic [31:0] got, exp;
        run_job(2, 1, 0, -1, -1, 0);
        idle_inputs();
        n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL g_timeout: got %0d, expected 0", timeout); end
        n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL g_cmd_in_gap: got %0d, expected 0", gap_bad); end
        n_checks++; if (qs_count() != 16) begin n_fail++; $display("FAIL g_qs_count: got %0d, expected 16", qs_count()); end
        n_checks++; if (qs_bad(2) != 0) begin n_fail++; $display("FAIL g_idx_continuity: got %0d bad, expected 0", qs_bad(2)); end
        n_checks++; if (out_q.size() != 8) begin n_fail++; $display("FAIL g_out_count: got %0d, expected 8", out_q.size()); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL g_result: got %h, expected %h", got, exp); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL g_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_abort();
        logic [31:0] got, exp;
        int          late_done;
        run_job(3, 0, 0, 10, -1, 0);
        n_checks++; if (aborted != 1) begin n_fail++; $display("FAIL ab_fired: got %0d, expected 1", aborted); end
        n_checks++; if (abort_cmd_bad != 0) begin n_fail++; $display("FAIL ab_cmd_in_abort: got %0d, expected 0", abort_cmd_bad); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b, expected 0", busy); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ab_o_valid: got %b, expected 0", o_valid); end
        late_done = done_cnt;
        repeat (3) begin
            @(negedge clk);
            if (done) late_done++;
        end
        n_checks++; if (late_done != 0) begin n_fail++; $display("FAIL ab_no_done: got %0d, expected 0", late_done); end
        n_checks++; if (out_q.size() == 0) begin n_fail++; $display("FAIL ab_some_outputs: got 0, expected >0"); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ab_partial_result: got %h, expected %h", got, exp); end
        end
        run_job(1, 0, 0, -1, -1, 0);
        idle_inputs();
        n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL ab_rerun_count: got %0d, expected 4", out_q.size()); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ab_rerun_result: got %h, expected %h", got, exp); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ab_rerun_done: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] got, exp;
        run_job(1, 0, 0, -1, 3, 1);
        n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL rd_timeout: got %0d, expected 0", timeout); end
        n_checks++; if (count_cmd(CMD_WRITE_WEIGHTS) != 4) begin n_fail++; $display("FAIL rd_restart_ignored: got %0d, expected 4", count_cmd(CMD_WRITE_WEIGHTS)); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy: got %b, expected 0", busy); end
        n_checks++; if (o_valid !== 1'b0 || o_data !== 32'h0) begin n_fail++; $display("FAIL rd_out: got %b/%h, expected 0/0", o_valid, o_data); end
        n_checks++; if (w_ready !== 1'b0 || a_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rd_hs: got %b%b%b, expected 000", w_ready, a_ready, done); end
        n_checks++; if (sa_cmd !== CMD_NONE || sa_in_val !== 32'h0 || sa_in_idx !== 2'd0) begin n_fail++; $display("FAIL rd_sa: got %0d/%h/%0d, expected 0/0/0", sa_cmd, sa_in_val, sa_in_idx); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        run_job(1, 0, 0, -1, -1, 0);
        idle_inputs();
        n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL rd_rerun_count: got %0d, expected 4", out_q.size()); end
        while (out_q.size() > 0 && exp_q.size() > 0) begin
            got = out_q.pop_front(); exp = exp_q.pop_front();
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rd_rerun_result: got %h, expected %h", got, exp); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rd_rerun_done: got %0d, expected 1", done_cnt); end
    endtask

    initial begin
        avals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                  32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                  32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
        foreach (wwords[i]) wwords[i] = '0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_weights_only();
        test_stream_m2();
        test_backpressure();
        test_gappy();
        test_abort();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_job_sequencer.md
# sa_job_sequencer

Sequencer that drives the TicSAT systolic array command port from streaming handshaked inputs, so a DMA or stream source can run a complete weight-load plus matrix-stream job without per-word CPU writes. It sits between the stream fabric and the `TicSAT_FP32_Int8_Pipelined` instance, beside the OBI wrapper. It converts two's-complement weights to sign-magnitude, issues `CMD_WRITE_WEIGHTS`, `CMD_QUEUE` and `CMD_STREAM` in order, and flushes the array pipeline. It discards the pipeline-fill outputs and presents exactly one result word per activation word.

## Interface
- `SA_SIZE`, default `heepstor_pkg::SYSTOLIC_ARRAY_SIZE` (4): array dimension; power of two, at least 2.
- `FILL_WORDS`, default `2*SA_SIZE`: number of leading output words discarded (array pipeline fill); must be at least 1.
- `WEIGHT_WORDS`, default `SA_SIZE*SA_SIZE/4`: 32-bit words (four int8 each) per weight load.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `start_i` in 1: job start pulse; sampled only in IDLE.
- `rows_i` in 16: number of activation vectors M; sampled with `start_i`.
- `abort_i` in 1: synchronous job abort.
- `busy_o` out 1: high when state is not IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `w_valid_i`, `w_ready_o`, `w_data_i[31:0]`: weight stream, two's-complement int8 x4.
- `a_valid_i`, `a_ready_o`, `a_data_i[31:0]`: activation stream, FP32.
- `o_valid_o`, `o_ready_i`, `o_data_o[31:0]`: result stream, FP32.
- `sa_cmd_o` out `TicSAT_pkg::command_t`: array command.
- `sa_in_val_o` out 32: array input value.
- `sa_in_idx_o` out `$clog2(SA_SIZE)`: array input index.
- `sa_out_i` in 32: array output; valid combinationally in the cycle a QUEUE or STREAM command is issued.

## Operation
- States are IDLE, LOAD_W, STREAM, DRAIN and DONE.
- **IDLE**: on `start_i`, latch `rows_i` and go to LOAD_W. Clear the word index `widx`, the row counter and the emitted-word counter.
- **LOAD_W**:
  - `w_ready_o` is 1.
  - On each `w_valid_i`: `sa_cmd_o=CMD_WRITE_WEIGHTS`, `sa_in_val_o` = per-byte sign-magnitude of `w_data_i` (via `twos_complement_to_sign_mag`), `sa_in_idx_o = widx[$clog2(SA_SIZE)-1:0]`.
  - After WEIGHT_WORDS accepted words: go to STREAM if M>0, else go to DONE.
- **STREAM**: one activation word per command.
  - `sa_in_val_o=a_data_i`, `sa_in_idx_o=widx mod SA_SIZE`.
  - Command is `CMD_STREAM` when idx = SA_SIZE-1, else `CMD_QUEUE`.
  - After M*SA_SIZE accepted words, go to DRAIN.
- **DRAIN**: issue FILL_WORDS flush commands. Data is 0; idx and the QUEUE/STREAM pattern continue from STREAM. Then go to DONE.
- **DONE**: `done_o`=1 for one cycle, then return to IDLE.
- **Output selection**: the k-th QUEUE/STREAM command (counting from 0 in the job) produces a kept output iff k ≥ FILL_WORDS. Kept outputs are loaded into a single output register. Total kept outputs = M*SA_SIZE.
- **Issue rule**: a QUEUE/STREAM command whose output is kept issues only if the output register is empty or is being consumed this cycle (`o_ready_i`). `a_ready_o` follows the same rule; `a_ready_o`=0 outside STREAM.
- DONE is entered only after the last kept word has left the output register.
- `sa_cmd_o=CMD_NONE` in every cycle where no command is issued.
- **abort_i**: takes priority over all other events. The next state is IDLE, and `o_valid_o` clears. No `done_o` pulse. No command is issued in the abort cycle.
- `start_i` while busy is ignored.

## Timing
- Reset values: `busy_o=0`, `done_o=0`, `w_ready_o=0`, `a_ready_o=0`, `o_valid_o=0`, `o_data_o=0`, `sa_cmd_o=CMD_NONE`, `sa_in_val_o=0`, `sa_in_idx_o=0`; state is IDLE.
- Reset asserted mid-job takes effect immediately and forces all of the above. Partial array contents are not cleared.
- `sa_cmd_o`, `sa_in_val_o` and `sa_in_idx_o` are combinational from state and the input handshake. This allows zero bubbles at one word per cycle.
- Output latency: a kept result appears on `o_valid_o` the cycle after its command.
- `start_i` to the first `w_ready_o`: 1 cycle.
- Minimum job length: 1 + WEIGHT_WORDS + M*SA_SIZE + FILL_WORDS + 2 cycles.
- Output handshake: an asserted `o_valid_o` holds with `o_data_o` stable until `o_ready_i`.

## Configuration
- `SA_SEQ_PERF_CNT_EN` defined:
  - Adds `stall_cycles_o[31:0]`, which counts busy cycles with no command issued.
  - Adds `job_cycles_o[31:0]`, which counts cycles from `start_i` acceptance to `done_o`.
  - Both counters clear on job start and hold after DONE; reset value is 0.
- `SA_SEQ_PERF_CNT_EN` undefined: these ports and counters do not exist.

## Test plan
- SA_SIZE=4, M=0, 4 weight words 0xFF01_80_7F back-to-back -> 4 `CMD_WRITE_WEIGHTS` with idx 0,1,2,3 and value 0x8101_80_7F each, then `done_o` pulse; no outputs.
- M=2, `o_ready_i`=1, activation words 1.0..8.0, known weights -> commands QUEUE,QUEUE,QUEUE,STREAM twice, then 8 flush commands; exactly 8 results matching the golden model; `done_o` after the last result.
- M=1 with `o_ready_i` held 0 for 10 cycles after the first kept result -> `a_ready_o`/flush commands stall; `o_data_o` is stable; no results are lost or duplicated.
- `a_valid_i` toggling every other cycle -> `sa_cmd_o=CMD_NONE` in gaps; idx continuity is preserved across gaps.
- `abort_i` during STREAM with `o_valid_o`=1 -> next cycle IDLE, `o_valid_o`=0, no `done_o`; a new job then completes correctly.
- `rst_i` pulsed mid-DRAIN -> all outputs take reset values immediately; `start_i` during busy has no effect.
